// File: rtl/onehot_index_fifo.sv
// Converts one-hot leftmost/rightmost encoder outputs to binary indices and
// buffers them in a small FIFO so the consumer can apply back-pressure.
module onehot_index_fifo #(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 8,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic                     clk_i,
   input  logic                     arst_n_i,
   input  logic [WIDTH-1:0]         data_left_i,
   input  logic [WIDTH-1:0]         data_right_i,
   input  logic                     data_val_i,
   output logic [IDX_W-1:0]         idx_left_o,
   output logic [IDX_W-1:0]         idx_right_o,
   output logic                     idx_none_o,
   output logic                     data_val_o,
   input  logic                     data_ready_i,
   output logic [$clog2(DEPTH):0]   usedw_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic                     overflow_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = 2 * IDX_W + 1;

   // Handshake: an entry transfers on a cycle where data_val_o && data_ready_i
   // are both high at the rising edge; data_val_o never depends on data_ready_i,
   // and the head entry holds stable while data_val_o && !data_ready_i.

   logic [ENT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             overflow_q;

   logic [IDX_W-1:0] enc_left;
   logic [IDX_W-1:0] enc_right;
   logic             enc_none;
   logic             push;
   logic             pop;
   logic             drop;

   // OR of set-bit positions: exact for one-hot, zero for an all-zero word.
   function automatic logic [IDX_W-1:0] encode(input logic [WIDTH-1:0] v);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) begin
            r = r | IDX_W'(i);
         end
      end
      return r;
   endfunction

   always_comb begin
      enc_left  = encode(data_left_i);
      enc_right = encode(data_right_i);
      enc_none  = (data_left_i == '0);
   end

   always_comb begin
      empty_o    = (count == '0);
      full_o     = (count == CNT_W'(DEPTH));
      usedw_o    = count;
      data_val_o = !empty_o;
      overflow_o = overflow_q;
      pop        = data_val_o && data_ready_i;
      push       = data_val_i && (!full_o || pop);
      drop       = data_val_i && full_o && !pop;
   end

   always_comb begin
      {idx_none_o, idx_right_o, idx_left_o} = mem[rd_ptr];
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= {enc_none, enc_right, enc_left};
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
         if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_onehot_index_fifo.sv
// Directed bench for onehot_index_fifo (WIDTH=16, DEPTH=8) with a queue
// scoreboard for the pass-through and random-traffic phases.
module tb_onehot_index_fifo;

   localparam int WIDTH = 16;
   localparam int DEPTH = 8;

   logic        clk_i;
   logic        arst_n_i;
   logic [15:0] data_left_i;
   logic [15:0] data_right_i;
   logic        data_val_i;
   logic [3:0]  idx_left_o;
   logic [3:0]  idx_right_o;
   logic        idx_none_o;
   logic        data_val_o;
   logic        data_ready_i;
   logic [3:0]  usedw_o;
   logic        full_o;
   logic        empty_o;
   logic        overflow_o;

   int compared   = 0;
   int mismatched = 0;

   logic [8:0] exp_q[$];
   logic       ovf_m;

   onehot_index_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk_i        (clk_i),
      .arst_n_i     (arst_n_i),
      .data_left_i  (data_left_i),
      .data_right_i (data_right_i),
      .data_val_i   (data_val_i),
      .idx_left_o   (idx_left_o),
      .idx_right_o  (idx_right_o),
      .idx_none_o   (idx_none_o),
      .data_val_o   (data_val_o),
      .data_ready_i (data_ready_i),
      .usedw_o      (usedw_o),
      .full_o       (full_o),
      .empty_o      (empty_o),
      .overflow_o   (overflow_o)
   );

   // clock / reset
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic val, input logic [15:0] l, input logic [15:0] r, input logic rdy);
      data_val_i   = val;
      data_left_i  = l;
      data_right_i = r;
      data_ready_i = rdy;
   endtask

   function automatic logic [8:0] ent(input logic none, input logic [3:0] ri, input logic [3:0] li);
      return {none, ri, li};
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_val"},   32'(data_val_o), 32'd0);
      check({tag, "_empty"}, 32'(empty_o), 32'd1);
      check({tag, "_full"},  32'(full_o), 32'd0);
      check({tag, "_usedw"}, 32'(usedw_o), 32'd0);
      check({tag, "_ovf"},   32'(overflow_o), 32'd0);
      check({tag, "_head"},  32'({idx_none_o, idx_right_o, idx_left_o}), 32'd0);
   endtask

   task automatic check_head(input string tag, input logic [8:0] exp);
      check(tag, 32'({idx_none_o, idx_right_o, idx_left_o}), 32'(exp));
   endtask

   initial begin
      logic [3:0] kl;
      logic [3:0] kr;
      logic       zero_w;
      logic       pop_m;
      logic       push_m;
      logic       val_r;
      logic       rdy_r;

      drive(1'b0, 16'h0, 16'h0, 1'b0);
      arst_n_i = 1'b0;
      #12;
      check_reset_outputs("rst");
      arst_n_i = 1'b1;
      tick();
      check_reset_outputs("idle");

      // single push, held under back-pressure
      drive(1'b1, 16'h8000, 16'h0001, 1'b0);
      tick();
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      check("push1_val", 32'(data_val_o), 32'd1);
      check("push1_left", 32'(idx_left_o), 32'd15);
      check("push1_right", 32'(idx_right_o), 32'd0);
      check("push1_none", 32'(idx_none_o), 32'd0);
      check("push1_usedw", 32'(usedw_o), 32'd1);
      tick();
      tick();
      check_head("push1_hold", ent(1'b0, 4'd0, 4'd15));
      check("push1_hold_val", 32'(data_val_o), 32'd1);

      // zero word behind it
      drive(1'b1, 16'h0000, 16'h0000, 1'b0);
      tick();
      check("zero_usedw", 32'(usedw_o), 32'd2);
      drive(1'b0, 16'h0, 16'h0, 1'b1);
      tick();
      check_head("zero_head", ent(1'b1, 4'd0, 4'd0));
      check("zero_usedw_after_pop", 32'(usedw_o), 32'd1);
      tick();
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      check("zero_drained_empty", 32'(empty_o), 32'd1);
      check("zero_drained_val", 32'(data_val_o), 32'd0);

      // fill with 9 pushes, ready low; pointers now start at 2 so this wraps
      for (int k = 0; k < 9; k++) begin
         drive(1'b1, 16'd1 << k, 16'd1 << k, 1'b0);
         tick();
         if (k == 7) begin
            check("fill_full", 32'(full_o), 32'd1);
            check("fill_usedw8", 32'(usedw_o), 32'd8);
            check("fill_no_ovf_yet", 32'(overflow_o), 32'd0);
         end
      end
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      check("drop_ovf", 32'(overflow_o), 32'd1);
      check("drop_usedw", 32'(usedw_o), 32'd8);
      check_head("drop_head", ent(1'b0, 4'd0, 4'd0));
      exp_q.delete();
      for (int k = 0; k < 8; k++) exp_q.push_back(ent(1'b0, 4'(k), 4'(k)));

      // full with simultaneous push/pop for 20 cycles
      for (int c = 0; c < 20; c++) begin
         kl = 4'((c + 3) % 16);
         kr = 4'(c % 16);
         drive(1'b1, 16'd1 << kl, 16'd1 << kr, 1'b1);
         check_head("pp_head", exp_q[0]);
         tick();
         void'(exp_q.pop_front());
         exp_q.push_back(ent(1'b0, kr, kl));
         check("pp_usedw", 32'(usedw_o), 32'd8);
         check("pp_ovf", 32'(overflow_o), 32'd1);
      end

      // drain
      drive(1'b0, 16'h0, 16'h0, 1'b1);
      for (int c = 0; c < 8; c++) begin
         check_head("drain_head", exp_q[0]);
         check("drain_val", 32'(data_val_o), 32'd1);
         tick();
         void'(exp_q.pop_front());
      end
      check("drain_empty", 32'(empty_o), 32'd1);
      check("drain_usedw", 32'(usedw_o), 32'd0);

      // async reset mid-stream with 3 entries stored
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 16'h4000, 16'h0010, 1'b0);
         tick();
      end
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      check("mid_usedw3", 32'(usedw_o), 32'd3);
      arst_n_i = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk_i);
      arst_n_i = 1'b1;
      tick();

      // random traffic against the queue model
      exp_q.delete();
      ovf_m = 1'b0;
      for (int c = 0; c < 300; c++) begin
         val_r  = 1'($urandom_range(0, 3) != 0);
         rdy_r  = 1'($urandom_range(0, 2) == 0);
         zero_w = 1'($urandom_range(0, 4) == 0);
         kl = 4'($urandom_range(0, 15));
         kr = 4'($urandom_range(0, 15));
         if (zero_w) drive(val_r, 16'h0, 16'h0, rdy_r);
         else        drive(val_r, 16'd1 << kl, 16'd1 << kr, rdy_r);
         check("rnd_val", 32'(data_val_o), 32'(exp_q.size() > 0));
         if (exp_q.size() > 0) check_head("rnd_head", exp_q[0]);
         pop_m  = (exp_q.size() > 0) && rdy_r;
         push_m = val_r && ((exp_q.size() < DEPTH) || pop_m);
         if (val_r && (exp_q.size() == DEPTH) && !pop_m) ovf_m = 1'b1;
         tick();
         if (pop_m) void'(exp_q.pop_front());
         if (push_m) begin
            if (zero_w) exp_q.push_back(ent(1'b1, 4'd0, 4'd0));
            else        exp_q.push_back(ent(1'b0, kr, kl));
         end
         check("rnd_usedw", 32'(usedw_o), 32'(exp_q.size()));
         check("rnd_ovf", 32'(overflow_o), 32'(ovf_m));
         check("rnd_full", 32'(full_o), 32'(exp_q.size() == DEPTH));
      end
      drive(1'b0, 16'h0, 16'h0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/onehot_index_fifo.md
# onehot_index_fifo

Downstream stage of the priority encoder: takes its registered one-hot outputs (leftmost and rightmost set bit) plus valid and converts each one-hot pair to binary bit indices. The pairs are buffered in a small FIFO with a valid/ready handshake toward the consumer. Absorbs back-pressure the encoder cannot handle, since the encoder has no ready input. Drops on overflow are flagged.

## Interface
- WIDTH, 16, width of the one-hot inputs; ≥2.
- DEPTH, 8, FIFO entries; power of two, ≥2.
- IDX_W (localparam), $clog2(WIDTH), index width.
- clk_i  input  1  clock, all logic on rising edge.
- arst_n_i  input  1  reset: one clock; reset is asynchronous and active-low.
- data_left_i  input  WIDTH  one-hot (or zero) leftmost set bit from encoder.
- data_right_i  input  WIDTH  one-hot (or zero) rightmost set bit from encoder.
- data_val_i  input  1  push request; inputs sampled when high.
- idx_left_o  output  IDX_W  head entry: index of leftmost set bit.
- idx_right_o  output  IDX_W  head entry: index of rightmost set bit.
- idx_none_o  output  1  head entry: source word was all zero.
- data_val_o  output  1  head entry valid (FIFO non-empty).
- data_ready_i  input  1  consumer accepts head entry.
- usedw_o  output  IDX_W'($clog2(DEPTH)+1)  entries stored, 0..DEPTH.
- full_o  output  1  usedw_o == DEPTH.
- empty_o  output  1  usedw_o == 0.
- overflow_o  output  1  sticky: a push was dropped.

## Operation
- Encode (combinational, on push side): index = OR of positions of set bits; one-hot input gives its exact position. Non-one-hot input is not checked; the OR result is stored as is.
- none = (data_left_i == 0); data_right_i is not consulted for none.
- Zero input stores idx_left = idx_right = 0, none = 1.
- Entry = {none, idx_right, idx_left}, stored in a DEPTH-entry register array. Write pointer and read pointer are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Count register is $clog2(DEPTH)+1 bits.
- push = data_val_i && (!full_o || pop).
- pop = data_val_o && data_ready_i.
- Push writes at wr_ptr and increments wr_ptr. Pop increments rd_ptr.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - unchanged on both or neither.
- Full and pop in the same cycle: push accepted, count stays DEPTH.
- Empty: pop impossible (data_val_o low). No input-to-output bypass.
- Drop: data_val_i && full_o && !pop. Entry discarded, overflow_o set. overflow_o is cleared only by reset.
- Outputs idx_*_o / idx_none_o are read from mem[rd_ptr] and are meaningful only while data_val_o is high. They must hold stable while data_val_o && !data_ready_i.
- data_val_o = !empty_o.

## Timing
- Reset (async assert, deassert synchronised externally):
  - pointers and count 0.
  - data_val_o 0, empty_o 1, full_o 0, usedw_o 0, overflow_o 0.
  - idx_left_o, idx_right_o, idx_none_o 0 (memory cleared).
- Reset asserted mid-operation discards all entries immediately, with no clock edge needed.
- Push at edge N: data_val_o high and entry visible from edge N (one-cycle latency, input sample to output valid).
- Pop at edge N: next entry (or data_val_o low) visible after edge N.
- usedw_o, full_o, empty_o and overflow_o are all registered, updated at the same edge as the triggering push, pop or drop.
- Throughput: one push and one pop per cycle, sustained.

## Test plan
- Reset then idle:
  - Response: all outputs 0 except empty_o = 1.
  - Assert arst_n_i low mid-stream with 3 entries stored → outputs return to reset values with no clock edge.
- Single push, WIDTH=16:
  - Stimulus: left = 16'h8000, right = 16'h0001, data_ready_i = 0.
  - Response: next cycle data_val_o = 1, idx_left_o = 15, idx_right_o = 0, idx_none_o = 0, usedw_o = 1. Outputs hold while ready stays low.
- Zero word:
  - Stimulus: left = right = 0 with data_val_i = 1.
  - Response: entry has idx_none_o = 1, idx_left_o = idx_right_o = 0.
- Fill and overflow, DEPTH=8, ready low:
  - Stimulus: 9 consecutive pushes of left = 1<<k, right = 1<<k, k = 0..8 (k=8 valid for WIDTH=16).
  - Response: full_o = 1 after the 8th push, usedw_o = 8. The 9th push is dropped and overflow_o = 1. Drain yields indices 0..7 in order, wrap-around correct.
- Full with simultaneous push/pop:
  - Stimulus: at full, data_val_i = 1 and data_ready_i = 1 for 20 cycles.
  - Response: no drops, overflow_o unchanged, usedw_o stays 8, order preserved across pointer wrap.
- Random traffic:
  - Stimulus: random valid/ready and random one-hot/zero pairs.
  - Response: outputs match a scoreboard queue model. usedw_o equals the model depth every cycle. overflow_o matches the model's drop condition.
